// File: rtl/layer_3_maxpool2x2.sv
// rtl/layer_3_maxpool2x2.sv - streaming 2x2 stride-2 max-pool over a raster binary32 feature map
//
// Purpose: consumes an IMG_SIZE x IMG_SIZE raster stream and emits one maximum
// per 2x2 window as an (IMG_SIZE/2) x (IMG_SIZE/2) raster stream.
//
// Ports:
//   Clk        in   1           rising-edge clock
//   Rst        in   1           asynchronous active-high reset
//   data_in    in   DATA_WIDTH  input pixel, raster order
//   valid_in   in   1           data_in qualifier; idle cycles allowed
//   data_out   out  DATA_WIDTH  pooled pixel, registered, held between strobes
//   valid_out  out  1           single-cycle strobe qualifying data_out
module layer_3_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 208
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_h;
  logic [DATA_WIDTH-1:0] r_buf [HALF];

  logic [BW-1:0]         w_idx;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [DATA_WIDTH-1:0] w_max2;
  logic [DATA_WIDTH-1:0] w_max3;

  // Sign/magnitude compare on raw bits: a positive value beats any negative,
  // larger magnitude wins among positives, smaller magnitude among negatives.
  // NaN/Inf simply fall into this ordering.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic a_neg;
    logic b_neg;
    logic a_mag_ge;
    a_neg    = a[DATA_WIDTH-1];
    b_neg    = b[DATA_WIDTH-1];
    a_mag_ge = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]);
    if (a_neg != b_neg)
      fmax = a_neg ? b : a;
    else if (!a_neg)
      fmax = a_mag_ge ? a : b;
    else
      fmax = a_mag_ge ? b : a;
  endfunction

  assign w_idx      = BW'(r_col >> 1);
  assign w_last_col = (r_col == CW'(IMG_SIZE - 1));
  assign w_last_row = (r_row == CW'(IMG_SIZE - 1));
  assign w_max2     = fmax(r_h, data_in);
  assign w_max3     = fmax(fmax(r_buf[w_idx], r_h), data_in);

  // Row buffer carries the even-row pair maxima down to the odd row; it is
  // always written before being read, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (valid_in && !Rst && r_col[0] && !r_row[0])
      r_buf[w_idx] <= w_max2;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_h       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (!r_col[0]) begin
          r_h <= data_in;
        end else if (r_row[0]) begin
          data_out  <= w_max3;
          valid_out <= 1'b1;
        end

        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule
